fifo_rd_fwft: RTL and testbench

//  Read-domain first-word-fall-through (FWFT) stage for the async FIFO.
//  - Sits directly downstream of the read-pointer/empty counter.
//  - Drives that counter's increment enable from the registered empty flag.
//  - Captures the registered RAM read data.
//  - Presents a valid/ready stream to the consumer at one word per clock.

---
 rtl/fifo_rd_fwft_pkg.sv | 32 +++
 rtl/fifo_rd_fwft_buf2.sv | 105 ++++++++++
 rtl/fifo_rd_fwft.sv | 93 +++++++++
 tb/tb_fifo_rd_fwft.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_fwft_pkg.sv
// Shared constants and types for the read-domain FWFT stage of the async FIFO.
//   FWFT_DEPTH : number of words the FWFT stage may hold locally
//   LEVEL_W    : width of the local fill level (counts 0..FWFT_DEPTH)
//   level_t    : type of the fill level
//   buf_op_e   : per-cycle operation applied to the 2-slot buffer
package fifo_rd_fwft_pkg;

  localparam int unsigned FWFT_DEPTH = 2;
  localparam int unsigned LEVEL_W    = 2;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    BufHold,
    BufPush,
    BufPop,
    BufPushPop
  } buf_op_e;

  // Collapse the push/pop strobes into a single decoded buffer operation.
  function automatic buf_op_e buf_op(input logic push, input logic pop);
    buf_op_e op;
    unique case ({push, pop})
      2'b10:   op = BufPush;
      2'b01:   op = BufPop;
      2'b11:   op = BufPushPop;
      default: op = BufHold;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fifo_rd_fwft_buf2.sv
// Two-slot shift buffer for the FWFT stage. slot0 is the head and is always
// presented on dout; slot1 is the tail. A pop shifts slot1 into slot0 in the
// same cycle. A push lands in the lowest slot that is free once this cycle's
// pop has been applied.
// Ports:
//   clk   in   read-domain clock
//   rst   in   asynchronous active-low reset
//   clr   in   synchronous clear, same effect as reset
//   push  in   write din this cycle
//   din   in   data to write
//   pop   in   remove the head word this cycle (ignored when empty)
//   dout  out  head word (slot0)
//   level out  number of words held (0..2)
module fwft_buf2
  import fifo_rd_fwft_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output level_t            level
);

  localparam level_t LevelZero = level_t'(0);
  localparam level_t LevelOne  = level_t'(1);
  localparam level_t LevelFull = level_t'(FWFT_DEPTH);

  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  level_t            level_q, level_d;
  logic              pop_ok;

  // A pop of an empty buffer has nothing to remove.
  assign pop_ok = pop && (level_q != LevelZero);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    level_d = level_q;
    unique case (buf_op(push, pop_ok))
      BufPush: begin
        level_d = level_q + LevelOne;
        if (level_q == LevelZero) begin
          slot0_d = din;
        end else begin
          slot1_d = din;
        end
      end
      BufPop: begin
        level_d = level_q - LevelOne;
        slot0_d = slot1_q;
        // Keep the vacated tail at zero so a drained buffer shows dout = 0.
        slot1_d = '0;
      end
      BufPushPop: begin
        // Level is unchanged; the head leaves and the new word takes the
        // first slot that is free after the shift.
        if (level_q == LevelFull) begin
          slot0_d = slot1_q;
          slot1_d = din;
        end else begin
          slot0_d = din;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      level_q <= LevelZero;
    end else if (clr) begin
      slot0_q <= '0;
      slot1_q <= '0;
      level_q <= LevelZero;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      level_q <= level_d;
    end
  end

  assign dout  = slot0_q;
  assign level = level_q;

  // The owner must never push into a full buffer without a matching pop.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst || clr)
      !(push && !pop_ok && (level_q == LevelFull))
  );

  a_level_range: assert property (
    @(posedge clk) disable iff (!rst)
      level_q <= LevelFull
  );

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-domain first-word-fall-through stage of the async FIFO.
// Sits downstream of the read-pointer/empty counter: it issues rd_en (the
// counter increment and RAM read strobe) from the registered empty flag,
// captures the RAM word one cycle later, and presents it as a valid/ready
// stream at up to one word per clock. Local storage is a 2-slot buffer;
// issue is throttled so buffered plus in-flight words never exceed 2.
// Ports:
//   clk        in   read-domain clock
//   rst        in   asynchronous active-low reset
//   clr        in   synchronous clear, same effect as reset
//   empty      in   registered empty flag from the read-pointer counter
//   rd_en      out  increment enable to the pointer counter / RAM read strobe
//   mem_rdata  in   RAM read data, valid the cycle after rd_en
//   dout       out  head-of-stream data
//   dout_valid out  dout holds a valid word
//   dout_ready in   consumer accepts dout this cycle
//   level      out  words held locally (0..2)
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output level_t            level
);

  localparam int unsigned CommitW = LEVEL_W + 1;
  localparam logic [CommitW-1:0] CommitMax = CommitW'(FWFT_DEPTH);

  logic               inflight_q;
  logic               pop;
  logic [CommitW-1:0] committed;

  fwft_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (inflight_q),
    .din   (mem_rdata),
    .pop   (pop),
    .dout  (dout),
    .level (level)
  );

  assign dout_valid = (level != level_t'(0));
  assign pop        = dout_valid && dout_ready;

  // Words that will still occupy the buffer after this cycle: held plus
  // returning minus leaving. pop implies level >= 1, so this cannot wrap.
  always_comb begin
    committed = {1'b0, level} + CommitW'(inflight_q) - CommitW'(pop);
  end

  // Gated by rst/clr so the cleared pointer counter never sees a stray
  // increment while the stage is being flushed.
  assign rd_en = rst && !clr && !empty && (committed < CommitMax);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
    end else if (clr) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
    end
  end

  a_no_overrun: assert property (
    @(posedge clk) disable iff (!rst)
      ({1'b0, level} + CommitW'(inflight_q)) <= CommitMax
  );

  a_no_read_when_empty: assert property (
    @(posedge clk) disable iff (!rst)
      rd_en |-> !empty
  );

  a_dout_stable: assert property (
    @(posedge clk) disable iff (!rst || clr)
      (dout_valid && !dout_ready) |=> (dout_valid && $stable(dout))
  );

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: a RAM/pointer model feeds mem_rdata, a scoreboard
// queue records every word issued by rd_en and is checked at each pop.
module tb_fifo_rd_fwft;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       empty;
  logic       rd_en;
  logic [7:0] mem_rdata;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [1:0] level;

  fifo_rd_fwft #(
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .empty      (empty),
    .rd_en      (rd_en),
    .mem_rdata  (mem_rdata),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       empty;
    logic       ready;
    logic       rd_en;
    logic       valid;
    logic [1:0] level;
    logic [7:0] dout;
  } vec_t;

  vec_t       tbl[17];
  logic [7:0] mem[64];
  int         rd_ptr;
  int         avail;
  bit         auto_empty;
  logic [7:0] sb[$];
  int         n_checks;
  int         n_errors;

  logic       s_rd_en;
  logic       s_valid;
  logic [1:0] s_level;
  logic [7:0] s_dout;

  int rd_cnt, first_rd, last_rd, v_cnt, first_v, last_v, stall_rd;
  logic [7:0] exp_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) mem[i] = base + 8'(i);
    avail  = n;
    rd_ptr = 0;
  endtask

  // One clock: sample just after the negedge inputs settle, update the
  // scoreboard, let the edge happen, then model the RAM/pointer response.
  task automatic cycle();
    logic       rd_s;
    logic       pop_s;
    logic [7:0] exp;
    #1;
    rd_s    = rd_en;
    pop_s   = dout_valid && dout_ready;
    s_rd_en = rd_en;
    s_valid = dout_valid;
    s_level = level;
    s_dout  = dout;
    if (rst && !clr) begin
      if (rd_s) sb.push_back(mem[rd_ptr]);
      if (pop_s) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pop_unexpected: got %0h expected no word at %0t", dout, $time);
        end else begin
          exp = sb.pop_front();
          chk("pop_data", dout, exp);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (!rst || clr) begin
      sb.delete();
      rd_ptr    = 0;
      mem_rdata = 8'($urandom);
    end else if (rd_s) begin
      mem_rdata = mem[rd_ptr];
      rd_ptr++;
    end else begin
      mem_rdata = 8'($urandom);
    end
    if (auto_empty) empty = (rd_ptr >= avail);
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n;
    n = 0;
    dout_ready = 1'b1;
    while (!(sb.size() == 0 && rd_ptr >= avail) && n < max_cyc) begin
      cycle();
      n++;
    end
    chk(name, 32'(sb.size() == 0 && rd_ptr >= avail), 32'd1);
  endtask

  // Flush by clr or by rst while one word is buffered and one is in flight.
  task automatic flush_test(input bit use_rst, input logic [7:0] base_a,
                            input logic [7:0] base_b, input string tag);
    bit found;
    load(base_a, 8);
    auto_empty = 1'b1;
    empty      = 1'b0;
    dout_ready = 1'b1;
    cycle();
    cycle();
    chk({tag, "_pre_level"}, 32'(level), 32'd1);
    dout_ready = 1'b0;
    if (use_rst) rst = 1'b0;
    else clr = 1'b1;
    cycle();
    chk({tag, "_rd_en_during"}, 32'(s_rd_en), 32'd0);
    rst        = 1'b1;
    clr        = 1'b0;
    auto_empty = 1'b0;
    empty      = 1'b1;
    load(base_b, 8);
    cycle();
    chk({tag, "_post_rd_en"}, 32'(s_rd_en), 32'd0);
    chk({tag, "_post_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_post_level"}, 32'(s_level), 32'd0);
    chk({tag, "_post_dout"}, 32'(s_dout), 32'd0);
    auto_empty = 1'b1;
    empty      = 1'b0;
    dout_ready = 1'b1;
    found      = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (s_valid) begin
        found = 1'b1;
        chk({tag, "_first_word"}, 32'(s_dout), 32'(base_b));
      end
    end
    if (!found) chk({tag, "_first_word_timeout"}, 32'd0, 32'd1);
    drain({tag, "_drain"}, 40);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              empty ready rd_en valid level dout
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h11};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h22};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h22};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h22};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h22};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h33};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h44};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'h44};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h55};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h55};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h66};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 8'h66};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 8'h77};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

    n_checks   = 0;
    n_errors   = 0;
    rd_ptr     = 0;
    avail      = 0;
    auto_empty = 1'b0;
    rst        = 1'b1;
    clr        = 1'b0;
    empty      = 1'b1;
    dout_ready = 1'b0;
    mem_rdata  = 8'h00;

    // Reset, then idle with empty=1 and junk on mem_rdata.
    #2 rst = 1'b0;
    #1;
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_dout", 32'(dout), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dout_ready = 1'($urandom);
      cycle();
      chk("idle_rd_en", 32'(s_rd_en), 32'd0);
      chk("idle_valid", 32'(s_valid), 32'd0);
      chk("idle_level", 32'(s_level), 32'd0);
      chk("idle_dout", 32'(s_dout), 32'd0);
    end

    // Table: first-word latency, back-pressure, push+pop at level 1, drain.
    for (int i = 0; i < 7; i++) mem[i] = 8'h11 * 8'(i + 1);
    rd_ptr = 0;
    foreach (tbl[i]) begin
      empty      = tbl[i].empty;
      dout_ready = tbl[i].ready;
      cycle();
      chk($sformatf("tbl%0d_rd_en", i), 32'(s_rd_en), 32'(tbl[i].rd_en));
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_level", i), 32'(s_level), 32'(tbl[i].level));
      if (tbl[i].valid) chk($sformatf("tbl%0d_dout", i), 32'(s_dout), 32'(tbl[i].dout));
    end
    chk("tbl_sb_empty", 32'(sb.size()), 32'd0);

    // Streaming 0x00..0x0F with dout_ready held high.
    load(8'h00, 16);
    auto_empty = 1'b1;
    empty      = 1'b0;
    dout_ready = 1'b1;
    rd_cnt = 0; first_rd = -1; last_rd = -1;
    v_cnt  = 0; first_v  = -1; last_v  = -1;
    for (int c = 0; c < 22; c++) begin
      cycle();
      if (s_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = c;
        last_rd = c;
      end
      if (s_valid) begin
        v_cnt++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
    end
    chk("stream_rd_cnt", 32'(rd_cnt), 32'd16);
    chk("stream_rd_first", 32'(first_rd), 32'd0);
    chk("stream_rd_span", 32'(last_rd - first_rd), 32'd15);
    chk("stream_out_cnt", 32'(v_cnt), 32'd16);
    chk("stream_out_latency", 32'(first_v - first_rd), 32'd2);
    chk("stream_out_span", 32'(last_v - first_v), 32'd15);
    chk("stream_sb_empty", 32'(sb.size()), 32'd0);

    // Back-pressure: 3 cycles flowing, 5 stalled, then release.
    load(8'h20, 12);
    empty      = 1'b0;
    dout_ready = 1'b1;
    repeat (3) cycle();
    dout_ready = 1'b0;
    stall_rd   = 0;
    for (int c = 0; c < 5; c++) begin
      exp_head = sb[0];
      cycle();
      if (s_rd_en) stall_rd++;
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_dout_held", 32'(s_dout), 32'(exp_head));
    end
    chk("bp_stall_issues", 32'(stall_rd), 32'd0);
    chk("bp_level", 32'(s_level), 32'd2);
    chk("bp_rd_en", 32'(s_rd_en), 32'd0);
    dout_ready = 1'b1;
    cycle();
    chk("bp_resume_rd_en", 32'(s_rd_en), 32'd1);
    drain("bp_drain", 40);

    // Flush mid-transfer by clr, then by reset.
    flush_test(1'b0, 8'h30, 8'h40, "clr");
    flush_test(1'b1, 8'h50, 8'h60, "rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
